pin_event_capture: RTL
======================

# pin_event_capture

Registered edge-event recorder that sits directly downstream of the `foo2` AND stage and consumes its `x` output. It timestamps every rising and falling transition of `x` against a free-running counter and buffers the events in a small FIFO. Each event is delivered through a valid/ready handshake, and the block keeps a high-time counter and overflow statistics for the control/debug block.

## Interface
- `TS_W`, 16: timestamp width in bits; legal range 8..32.
- `DEPTH`, 4: event FIFO depth; power of two, at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `en`  in  1  capture enable; low freezes the sampler and timestamp counter.
- `x_i`  in  1  AND result from `foo2.x`, same clock domain.
- `clr`  in  1  synchronous clear of `overflow`, `drop_cnt` and `high_cnt`.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_data`  out  TS_W+1  head event: bit TS_W is 1 for a rise and 0 for a fall; bits [TS_W-1:0] hold the timestamp.
- `overflow`  out  1  sticky: at least one event was dropped.
- `drop_cnt`  out  8  dropped-event count, saturates at 255.
- `high_cnt`  out  16  cycles with sampled x = 1, saturates at 65535.

## Operation
- Reset values:
  - `evt_valid`, `overflow`, `drop_cnt`, `high_cnt` and `evt_data` are 0.
  - Internal sample `x_q` is 0, timestamp counter `ts` is 0, FIFO is empty.
- Sampling (`en` = 1):
  - `x_q` takes `x_i` every edge.
  - An edge event exists when `x_i` != `x_q`; rise means `x_i` = 1.
- Timestamp (`en` = 1):
  - `ts` increments every edge and wraps from 2^TS_W−1 to 0.
  - The recorded timestamp is `ts` before the increment, i.e. the value in the detecting cycle.
- `en` = 0:
  - `x_q`, `ts` and `high_cnt` hold.
  - No events are pushed; pops continue.
  - On re-enable, the first sample compares against the held `x_q`, so a change made while disabled yields exactly one event.
- `high_cnt` increments on each enabled edge where `x_q` = 1 (value before update), saturating.
- FIFO:
  - Push on every edge event.
  - Pop when `evt_valid` and `evt_ready` are both 1.
  - Push while full with a simultaneous pop: both occur, and the count stays at DEPTH.
  - Push while full without a pop: the event is dropped, `overflow` is set, and `drop_cnt` increments (saturating).
  - Pop while empty: no effect.
  - `evt_data` is the head entry and is stable while `evt_valid` = 1 and `evt_ready` = 0.
- `clr`:
  - Zeroes `overflow`, `drop_cnt` and `high_cnt` on that edge.
  - If a drop occurs on the same edge, the result is `overflow` = 1 and `drop_cnt` = 1.
  - If `x_q` = 1 on the same edge, `high_cnt` = 0 (clear wins over the increment).
  - Does not touch the FIFO or `ts`.
- Reset mid-operation: all state returns immediately to reset values and buffered events are lost.

## Timing
- Input-to-output latency is 1 cycle: a transition seen at edge k makes `evt_valid` high after edge k when the FIFO was empty.
- Throughput:
  - One event per cycle in and one per cycle out.
  - A consumer holding `evt_ready` = 1 drains one event per cycle.
  - Back-to-back toggles of `x_i` produce one event per cycle with consecutive timestamps.
- All outputs are registered or driven from FIFO storage and the read pointer only; there is no combinational path from `x_i` or `evt_ready` to outputs.
- `rst_n` deassertion is synchronised externally; the first enabled edge after release is timestamp 0.

## Structure
- Shared header `pin_evt_defs`:
  - default `TS_W`, `DEPTH`;
  - event bit positions (`EVT_RISE_BIT`, timestamp field);
  - `DROP_W` = 8 and `HIGH_W` = 16.
- Sub-module `pin_evt_fifo`:
  - parameterised width/depth synchronous FIFO;
  - pointer-plus-wrap-bit full/empty;
  - full-with-pop push allowed.
- The top level holds the sampler, `ts` counter, `high_cnt`, drop logic and `clr`.

## Test plan
- Rising edge:
  - Stimulus: reset, `en` = 1, `x_i` = 0 for 5 cycles, then 1; `evt_ready` = 1.
  - Required: one event with `evt_data` = {1, 16'd5}; `evt_valid` high for 1 cycle; `high_cnt` increments from the following cycle.
- Fall after high period:
  - Stimulus: `x_i` high for 3 cycles, then low.
  - Required: events rise@t and fall@t+3; `high_cnt` = 3.
- Back-pressure and overflow:
  - Stimulus: `evt_ready` = 0, `x_i` toggling every cycle for 6 cycles.
  - Required: 4 events buffered in order; `overflow` = 1; `drop_cnt` = 2.
  - Then `evt_ready` = 1: the 4 events drain with consecutive timestamps 0..3.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, `evt_ready` = 1, toggle `x_i` once.
  - Required: no drop; count stays 4; the new event exits last.
- Disable and clear:
  - Stimulus: `en` = 0 with `ts` = 10, change `x_i`, then re-enable.
  - Required: exactly one event with timestamp 10.
  - `clr` pulse on a dropping edge: `drop_cnt` = 1, `overflow` = 1.
- Timestamp wrap and async reset:
  - Stimulus: `TS_W` = 8; an event at `ts` = 255, then one at 0.
  - Required: timestamps 255 and 0 recorded.
  - Assert `rst_n` mid-stream: `evt_valid`, `ts` and the counters are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pin_evt_defs.sv
// Shared definitions for the pin edge-event recorder.
// Holds the default geometry, the layout of an event word and the widths of
// the statistics counters. No ports; imported by pin_evt_fifo and
// pin_event_capture.
package pin_evt_defs;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 4;

  // Event word layout: {rise, timestamp[TS_W-1:0]}
  localparam int EVT_TS_LSB   = 0;
  localparam int EVT_RISE_BIT = TS_W_DEF;

  localparam int DROP_W = 8;
  localparam int HIGH_W = 16;

  // Position of the rise flag for a non-default timestamp width.
  function automatic int evt_rise_bit(input int ts_w);
    return ts_w;
  endfunction

endpackage

// File: rtl/pin_evt_fifo.sv
// Synchronous FIFO for edge events.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   push, wr_data write request and data
//   pop           read request (ignored while empty)
//   rd_data       head entry, forced to 0 while empty
//   empty, full   status, registered-pointer derived
// Full/empty use a pointer with an extra wrap bit. A push while full is
// accepted when a pop happens on the same edge, so the count stays at DEPTH.
module pin_evt_fifo
  import pin_evt_defs::*;
#(
  parameter int WIDTH = TS_W_DEF + 1,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; the empty gate below keeps the output defined.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/pin_event_capture.sv
// Edge-event recorder for the registered AND result x.
// Timestamps each rise/fall of x_i against a free-running counter and
// queues the events for a valid/ready consumer.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          capture enable (freezes sampler, ts and high_cnt when low)
//   x_i         monitored signal, same clock domain
//   clr         synchronous clear of overflow/drop_cnt/high_cnt
//   evt_valid, evt_ready, evt_data   event handshake, data = {rise, ts}
//   overflow    sticky drop flag
//   drop_cnt    saturating dropped-event count
//   high_cnt    saturating count of enabled cycles with sampled x = 1
module pin_event_capture
  import pin_evt_defs::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              x_i,
  input  logic              clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [TS_W:0]     evt_data,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [HIGH_W-1:0] high_cnt
);

  localparam int RISE_BIT = evt_rise_bit(TS_W);

  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  function automatic logic [HIGH_W-1:0] sat_inc_high(input logic [HIGH_W-1:0] v);
    return (&v) ? v : v + HIGH_W'(1);
  endfunction

  logic            x_q;
  logic [TS_W-1:0] ts;
  logic            edge_evt;
  logic [TS_W:0]   evt_word;
  logic            fifo_empty;
  logic            fifo_full;
  logic            drop;

  assign edge_evt = en && (x_i != x_q);

  always_comb begin
    evt_word                   = '0;
    evt_word[RISE_BIT]         = x_i;
    evt_word[TS_W-1:EVT_TS_LSB] = ts;
  end

  // A full FIFO only makes room when the head leaves on this same edge.
  assign drop = edge_evt && fifo_full && !evt_ready;

  // Sampler and timestamp stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 1'b0;
      ts  <= '0;
    end else if (en) begin
      x_q <= x_i;
      ts  <= ts + TS_W'(1);
    end
  end

  // Statistics stage; clr zeroes first, a coincident drop still counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      high_cnt <= '0;
    end else begin
      if (clr) begin
        overflow <= drop;
        drop_cnt <= drop ? DROP_W'(1) : '0;
        high_cnt <= '0;
      end else begin
        if (drop) begin
          overflow <= 1'b1;
          drop_cnt <= sat_inc_drop(drop_cnt);
        end
        if (en && x_q) high_cnt <= sat_inc_high(high_cnt);
      end
    end
  end

  pin_evt_fifo #(
    .WIDTH (TS_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (edge_evt),
    .wr_data (evt_word),
    .pop     (evt_ready),
    .rd_data (evt_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign evt_valid = !fifo_empty;

endmodule
